// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and checksum helper for the UART command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] CMD_STEP = 8'h01;
    localparam logic [7:0] CMD_MAXA = 8'h02;
    localparam logic [7:0] CMD_GAIN = 8'h03;
    localparam logic [7:0] CMD_PLAY = 8'h04;

    // HDR + CMD + 4 payload bytes + CS
    localparam int FRAME_LEN = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

    // Expected checksum: XOR of the command byte and all four payload bytes.
    function automatic logic [7:0] frame_cs(input logic [7:0] cmd, input logic [31:0] pl);
        return cmd ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
    endfunction

endpackage

// File: rtl/uart_cmd_tmo.sv
// Inter-byte timeout counter: cleared by clr, counts while en, pulses expire
// combinationally in the cycle the count sits at TMO_CYC-1 with no clear.
module uart_cmd_tmo #(
    parameter int TMO_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A strobe (clr) always wins over expiry.
    assign expire = en && !clr && (cnt_q == CW'(TMO_CYC - 1));

    // Next count: restart on clear or expiry, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_dec.sv
// Framed UART command decoder driving the ROM playback configuration.
// Frame: A5 CMD D3 D2 D1 D0 CS, CS = CMD^D3^D2^D1^D0.
// Optional inter-byte timeout compiled in with UART_CMD_TMO_EN.
// Input handshake: uart_in is qualified by the one-cycle strobe uart_rcv; there
// is no backpressure, every strobed byte is consumed in the cycle it arrives.
module uart_cmd_dec
    import uart_cmd_pkg::*;
#(
    parameter int          TMO_CYC  = 50000,
    parameter logic [31:0] STEP_RST = 32'd477901,
    parameter logic [15:0] MAXA_RST = 16'd12586,
    parameter logic [7:0]  GAIN_RST = 8'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_in,
    input  logic        uart_rcv,
    output logic [31:0] step_out,
    output logic [15:0] max_adr_out,
    output logic [7:0]  gain_out,
    output logic        play,
    output logic        cfg_upd,
    output logic        frm_err,
    output logic        tst
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] step_q, step_d;
    logic [15:0] maxa_q, maxa_d;
    logic [7:0]  gain_q, gain_d;
    logic        play_q, play_d;
    logic        cfg_upd_q, cfg_upd_d;
    logic        frm_err_q, frm_err_d;
    logic        tst_q, tst_d;
    logic        tmo_exp;

`ifdef UART_CMD_TMO_EN
    uart_cmd_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (uart_rcv),
        .en     (state_q != IDLE),
        .expire (tmo_exp)
    );
`else
    // No timeout: a partial frame waits indefinitely. The comparison is always
    // false and only keeps TMO_CYC referenced.
    assign tmo_exp = (TMO_CYC < 0);
`endif

    // Next-state, frame assembly, command execution and pulse generation.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        idx_d     = idx_q;
        step_d    = step_q;
        maxa_d    = maxa_q;
        gain_d    = gain_q;
        play_d    = play_q;
        cfg_upd_d = 1'b0;
        frm_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (uart_rcv && uart_in == HDR) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (uart_rcv) begin
                    cmd_d   = uart_in;
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                // 0xA5 is plain data here; no resynchronisation inside a frame.
                if (uart_rcv) begin
                    data_d = {data_q[23:0], uart_in};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (uart_rcv) begin
                    state_d = IDLE;
                    if (uart_in == frame_cs(cmd_q, data_q)) begin
                        cfg_upd_d = 1'b1;
                        case (cmd_q)
                            CMD_STEP: step_d = data_q;
                            CMD_MAXA: maxa_d = data_q[15:0];
                            CMD_GAIN: gain_d = data_q[7:0];
                            CMD_PLAY: play_d = data_q[0];
                            default: begin
                                cfg_upd_d = 1'b0;
                                frm_err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry only happens without a strobe, so it never meets a CS execution.
        if (tmo_exp) begin
            state_d   = IDLE;
            frm_err_d = 1'b1;
        end

        tst_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            step_q    <= STEP_RST;
            maxa_q    <= MAXA_RST;
            gain_q    <= GAIN_RST;
            play_q    <= 1'b0;
            cfg_upd_q <= 1'b0;
            frm_err_q <= 1'b0;
            tst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            maxa_q    <= maxa_d;
            gain_q    <= gain_d;
            play_q    <= play_d;
            cfg_upd_q <= cfg_upd_d;
            frm_err_q <= frm_err_d;
            tst_q     <= tst_d;
        end
    end

    assign step_out    = step_q;
    assign max_adr_out = maxa_q;
    assign gain_out    = gain_q;
    assign play        = play_q;
    assign cfg_upd     = cfg_upd_q;
    assign frm_err     = frm_err_q;
    assign tst         = tst_q;

endmodule

// File: tb/tb_uart_cmd_dec.sv
// Directed self-checking bench for uart_cmd_dec.
// Builds with or without UART_CMD_TMO_EN; the timeout section adapts.
module tb_uart_cmd_dec;

    localparam int TMO = 100;

    logic        clk;
    logic        rst;
    logic [7:0]  uart_in;
    logic        uart_rcv;
    logic [31:0] step_out;
    logic [15:0] max_adr_out;
    logic [7:0]  gain_out;
    logic        play;
    logic        cfg_upd;
    logic        frm_err;
    logic        tst;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the configuration outputs
    logic [31:0] exp_step;
    logic [15:0] exp_maxa;
    logic [7:0]  exp_gain;
    logic        exp_play;

    uart_cmd_dec #(
        .TMO_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .uart_rcv    (uart_rcv),
        .step_out    (step_out),
        .max_adr_out (max_adr_out),
        .gain_out    (gain_out),
        .play        (play),
        .cfg_upd     (cfg_upd),
        .frm_err     (frm_err),
        .tst         (tst)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_step"}, step_out, exp_step);
        check({tag, "_maxa"}, 32'(max_adr_out), 32'(exp_maxa));
        check({tag, "_gain"}, 32'(gain_out), 32'(exp_gain));
        check({tag, "_play"}, 32'(play), 32'(exp_play));
    endtask

    task automatic model_reset();
        exp_step = 32'd477901;
        exp_maxa = 16'd12586;
        exp_gain = 8'd11;
        exp_play = 1'b0;
    endtask

    // Drive one strobed byte; returns #1 after the sampling edge with rcv still high.
    task automatic send_byte(input logic [7:0] b);
        uart_in  = b;
        uart_rcv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rcv_off();
        uart_rcv = 1'b0;
        uart_in  = 8'h00;
    endtask

    // Seven bytes back-to-back, MSB byte first.
    task automatic send_frame(input logic [55:0] f);
        for (int i = 6; i >= 0; i--) begin
            send_byte(f[i*8 +: 8]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_err;
        int cyc;

        rst      = 1'b1;
        uart_rcv = 1'b0;
        uart_in  = 8'h00;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset values
        check_cfg("rst");
        check("rst_cfg_upd", 32'(cfg_upd), 0);
        check("rst_frm_err", 32'(frm_err), 0);
        check("rst_tst", 32'(tst), 0);

        // Junk before header is ignored, then a step frame
        send_byte(8'h12);
        send_byte(8'h34);
        check("junk_tst", 32'(tst), 0);
        send_byte(8'hA5);
        check("hdr_tst", 32'(tst), 1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h0E);
        send_byte(8'hA9);
        send_byte(8'h5A);
        check("pre_cs_step", step_out, exp_step);
        send_byte(8'hFC);
        rcv_off();
        exp_step = 32'h000E_A95A;
        check_cfg("stepA");
        check("stepA_upd", 32'(cfg_upd), 1);
        check("stepA_err", 32'(frm_err), 0);
        check("stepA_tst", 32'(tst), 0);
        tick();
        check("stepA_upd_w", 32'(cfg_upd), 0);

        // Bad checksum, then a play frame with no gap
        send_frame(56'hA5_01_00_0E_A9_5A_FD);
        check_cfg("badcs");
        check("badcs_err", 32'(frm_err), 1);
        check("badcs_upd", 32'(cfg_upd), 0);
        send_frame(56'hA5_04_00_00_00_01_05);
        rcv_off();
        exp_play = 1'b1;
        check_cfg("play");
        check("play_upd", 32'(cfg_upd), 1);
        check("play_err", 32'(frm_err), 0);
        tick();
        check("play_upd_w", 32'(cfg_upd), 0);

        // Unknown command
        send_frame(56'hA5_07_00_00_00_00_07);
        rcv_off();
        check_cfg("unk");
        check("unk_err", 32'(frm_err), 1);
        check("unk_upd", 32'(cfg_upd), 0);
        tick();
        check("unk_err_w", 32'(frm_err), 0);

        // 0xA5 inside the payload is data
        send_frame(56'hA5_01_A5_00_00_01_A5);
        rcv_off();
        exp_step = 32'hA500_0001;
        check_cfg("a5data");
        check("a5data_upd", 32'(cfg_upd), 1);
        tick();

        // Partial frame: timeout or indefinite wait
        send_byte(8'hA5);
        send_byte(8'h02);
        rcv_off();
        n_err = 0;
`ifdef UART_CMD_TMO_EN
        cyc = 0;
        while (cyc < 150 && frm_err !== 1'b1) begin
            tick();
            cyc++;
        end
        check("tmo_lat", 32'(cyc), 100);
        check("tmo_tst", 32'(tst), 0);
        check("tmo_upd", 32'(cfg_upd), 0);
        tick();
        check("tmo_err_w", 32'(frm_err), 0);
        check_cfg("tmo");
        send_frame(56'hA5_02_00_00_0F_FF_F2);
`else
        for (cyc = 0; cyc < 150; cyc++) begin
            tick();
            if (frm_err === 1'b1) n_err++;
        end
        check("notmo_err", 32'(n_err), 0);
        check("notmo_tst", 32'(tst), 1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0F);
        send_byte(8'hFF);
        send_byte(8'hF2);
`endif
        rcv_off();
        exp_maxa = 16'h0FFF;
        check_cfg("maxa");
        check("maxa_upd", 32'(cfg_upd), 1);
        tick();

        // Reset in the middle of a gain frame (after D2)
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        rcv_off();
        check("mid_tst", 32'(tst), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_cfg("midrst");
        check("midrst_tst", 32'(tst), 0);
        check("midrst_upd", 32'(cfg_upd), 0);
        check("midrst_err", 32'(frm_err), 0);

        send_frame(56'hA5_03_00_00_00_05_06);
        rcv_off();
        exp_gain = 8'd5;
        check_cfg("gain");
        check("gain_upd", 32'(cfg_upd), 1);
        tick();

        // Same value again still pulses cfg_upd
        send_frame(56'hA5_03_00_00_00_05_06);
        rcv_off();
        check_cfg("gain2");
        check("gain2_upd", 32'(cfg_upd), 1);
        tick();
        check("gain2_upd_w", 32'(cfg_upd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_dec.md
# uart_cmd_dec

Byte-stream command decoder sitting directly upstream of the ROM playback stage. Accepts received UART bytes, assembles fixed-length framed commands, checks them, and drives the playback stage's configuration: phase-accumulator step, ROM wrap address, output gain and play enable. All outputs are registered and hold their value until a valid frame changes them.

## Interface
Parameters:
- TMO_CYC, 50000: inter-byte timeout in clk cycles; a frame in progress is aborted when this is exceeded.
- STEP_RST, 477901: reset value of step_out.
- MAXA_RST, 12586: reset value of max_adr_out.
- GAIN_RST, 11: reset value of gain_out.

Ports:
- clk, in, 1: sole clock; everything is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- uart_in, in, 8: received byte; valid only in a cycle where uart_rcv=1.
- uart_rcv, in, 1: one-cycle byte strobe. May be asserted on consecutive cycles.
- step_out, out, 32: phase step; reset STEP_RST.
- max_adr_out, out, 16: last ROM address before wrap; reset MAXA_RST.
- gain_out, out, 8: sample multiplier; reset GAIN_RST.
- play, out, 1: playback enable; reset 0.
- cfg_upd, out, 1: one-cycle pulse when any configuration output changes due to a frame; reset 0.
- frm_err, out, 1: one-cycle pulse on a bad checksum, unknown command or timeout; reset 0.
- tst, out, 1: high while the FSM is not IDLE; reset 0.

## Operation
- Frame, 7 bytes: HDR=0xA5, CMD, D3, D2, D1, D0 (big-endian payload), CS.
- CS must equal CMD^D3^D2^D1^D0.
- FSM states:
  - IDLE: a byte 0xA5 moves to CMD. Any other byte is discarded silently.
  - CMD: latch the byte and clear the payload shift register. Move to DATA with byte index 0.
  - DATA: shift the byte in. After the 4th byte, move to CSUM.
  - CSUM: compare and execute, then return to IDLE.
- Inside a frame, 0xA5 is ordinary data; there is no resynchronisation on it.
- Command execution, only when CS matches:
  - 0x01: step_out <= payload[31:0].
  - 0x02: max_adr_out <= payload[15:0].
  - 0x03: gain_out <= payload[7:0].
  - 0x04: play <= payload[0].
  - Upper payload bits are ignored where unused.
- Pulses:
  - A valid, known command pulses cfg_upd, even when the written value is unchanged.
  - A CS mismatch or an unknown CMD pulses frm_err. Outputs are unchanged. The FSM returns to IDLE.
- Timeout: a counter clears on every strobe and counts while the FSM is not IDLE. On reaching TMO_CYC, the FSM goes to IDLE and frm_err pulses.
- rst in any state: FSM to IDLE, counter and shift register cleared, all outputs to their reset values.

## Timing
- The byte is sampled in the cycle uart_rcv=1. The state change is visible on the next cycle.
- CS strobe in cycle N: the new output value and the cfg_upd (or frm_err) pulse appear together in cycle N+1.
- cfg_upd and frm_err are never high in the same cycle. Each is exactly 1 cycle wide.
- Back-to-back frames with no idle cycles are fully supported. The HDR strobe of frame 2 in cycle N+1 is accepted.
- A strobe in the same cycle the counter would reach TMO_CYC: the strobe wins. The byte is accepted, the counter clears, and there is no error.
- The timeout fires in the cycle the counter equals TMO_CYC-1 with no strobe. frm_err is visible in the following cycle.

## Configuration
- UART_CMD_TMO_EN defined: the timeout counter and the timeout abort are compiled in as described.
- Not defined: no counter. A partial frame waits indefinitely, and frm_err comes only from CS or CMD errors. TMO_CYC is ignored.

## Structure
- Package uart_cmd_pkg:
  - HDR constant 0xA5.
  - Command code constants CMD_STEP=0x01, CMD_MAXA=0x02, CMD_GAIN=0x03, CMD_PLAY=0x04.
  - FSM state enum (IDLE, CMD, DATA, CSUM).
  - Frame length constant 7.
- One natural sub-module, uart_cmd_tmo: the clear/enable timeout counter with an expiry pulse. Instantiated only under UART_CMD_TMO_EN.

## Test plan
- Reset release, no strobes: step_out=477901, max_adr_out=12586, gain_out=11, play=0, cfg_upd=frm_err=tst=0.
- Frame A5 01 00 0E A9 5A, with CS=01^00^0E^A9^5A=0xFC: step_out=0x000EA95A one cycle after the CS strobe, with a cfg_upd pulse of 1 cycle.
- Same frame with CS=0xFD: frm_err pulse, step_out unchanged. An A5 04 00 00 00 01 05 frame immediately following sets play=1.
- Unknown command A5 07 00 00 00 00 07: frm_err pulse, no output change. Also: junk bytes 12 34 before a header are ignored.
- With UART_CMD_TMO_EN and TMO_CYC=100: send A5 02, then wait 100 cycles. frm_err pulses and tst drops. A following full 0x02 frame with payload 0x00000FFF sets max_adr_out=0x0FFF.
- Assert rst in the middle of a gain frame (after D2): all outputs return to reset values and tst=0. A fresh A5 03 00 00 00 05 06 frame sets gain_out=5.
